// File: rtl/tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single UART transmitter.
// One byte per grant; a transfer ends on tx_done_tick or on a bounded timeout.
module tx_arbiter #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned TIMEOUT = 65536
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0,
    input  logic            req1,
    input  logic [DBIT-1:0] din0,
    input  logic [DBIT-1:0] din1,
    output logic            ack0,
    output logic            ack1,
    output logic            done0,
    output logic            done1,
    output logic            tx_start,
    output logic [DBIT-1:0] tx_din,
    input  logic            tx_done_tick,
    output logic            busy,
    output logic            err
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count, count_next;
    logic            rr, rr_next;          // last requester served
    logic            winner, winner_next;
    logic [DBIT-1:0] tx_din_next;
    logic            tx_start_next, ack0_next, ack1_next;
    logic            done0_next, done1_next, busy_next, err_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            rr       <= 1'b1;
            winner   <= 1'b0;
            tx_din   <= '0;
            tx_start <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            rr       <= rr_next;
            winner   <= winner_next;
            tx_din   <= tx_din_next;
            tx_start <= tx_start_next;
            ack0     <= ack0_next;
            ack1     <= ack1_next;
            done0    <= done0_next;
            done1    <= done1_next;
            busy     <= busy_next;
            err      <= err_next;
        end
    end

    // Outputs are computed for the next state so every output is a flop.
    always_comb begin
        state_next    = state;
        count_next    = count;
        rr_next       = rr;
        winner_next   = winner;
        tx_din_next   = tx_din;
        tx_start_next = 1'b0;
        ack0_next     = 1'b0;
        ack1_next     = 1'b0;
        done0_next    = 1'b0;
        done1_next    = 1'b0;
        err_next      = 1'b0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    winner_next   = (req0 && req1) ? ~rr : req1;
                    tx_din_next   = winner_next ? din1 : din0;
                    state_next    = START;
                    tx_start_next = 1'b1;
                    ack0_next     = ~winner_next;
                    ack1_next     = winner_next;
                end
            end
            START: begin
                state_next = BUSY;
                count_next = '0;
            end
            BUSY: begin
                if (tx_done_tick) begin
                    state_next = IDLE;
                    rr_next    = winner;
                    done0_next = ~winner;
                    done1_next = winner;
                end else if (count == LAST) begin
                    state_next = IDLE;
                    rr_next    = winner;
                    err_next   = 1'b1;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule
